// File: rtl/image_fetch_arbiter.sv
// Round-robin arbiter sharing a byte-wide image ROM between the vector load unit (port 0)
// and display scan-out (port 1); each grant reads LANES bytes and packs them little-endian.
//   state | meaning
//   IDLE  | arbitrate between req0/req1
//   FETCH | one ROM byte per cycle, idx 0..LANES-1
//   DONE  | result registered, doneN high for this cycle
module image_fetch_arbiter #(
  parameter int          LANES     = 4,
  parameter int unsigned IMG_BYTES = 152100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [31:0]          addr0,
  input  logic [31:0]          addr1,
  output logic [31:0]          rom_addr,
  input  logic [31:0]          rom_rd,
  output logic [8*LANES-1:0]   data0,
  output logic [8*LANES-1:0]   data1,
  output logic                 done0,
  output logic                 done1,
  output logic                 err0,
  output logic                 err1,
  output logic                 busy
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [31:0]             base_q, base_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic                    err_acc_q, err_acc_d;
  logic [LANES-1:0][7:0]   buf_q, buf_d;
  logic [8*LANES-1:0]      data0_q, data0_d, data1_q, data1_d;
  logic                    err0_q, err0_d, err1_q, err1_d;
  logic                    done0_q, done0_d, done1_q, done1_d;

  logic [31:0]             lane_addr;
  logic                    lane_oob;
  logic [7:0]              lane_byte;
  logic                    grant;
  logic                    unused_rom_hi;

  // Only the low byte of the ROM word carries pixel data.
  assign unused_rom_hi = ^rom_rd[31:8];

  always_comb begin
    lane_addr = base_q + 32'(idx_q);
    lane_oob  = (lane_addr >= IMG_BYTES);
    lane_byte = lane_oob ? 8'h00 : rom_rd[7:0];
  end

  assign rom_addr = (state_q == FETCH) ? lane_addr : 32'h0;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    err_acc_d    = err_acc_q;
    buf_d        = buf_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    // On contention the port that was not served last wins.
    grant        = (req0 && req1) ? ~last_owner_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          base_d       = grant ? addr1 : addr0;
          owner_d      = grant;
          last_owner_d = grant;
          idx_d        = '0;
          err_acc_d    = 1'b0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        buf_d[idx_q] = lane_byte;
        err_acc_d    = err_acc_q | lane_oob;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          if (owner_q) begin
            data1_d = buf_d;
            err1_d  = err_acc_d;
            done1_d = 1'b1;
          end else begin
            data0_d = buf_d;
            err0_d  = err_acc_d;
            done0_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      err_acc_q    <= 1'b0;
      buf_q        <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      err_acc_q    <= err_acc_d;
      buf_q        <= buf_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign data0 = data0_q;
  assign data1 = data1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: doc/image_fetch_arbiter.md
# image_fetch_arbiter

Shares the single-byte-per-access image ROM between two requesters: port 0 is the vector load unit and port 1 is the display scan-out. For each granted request, the block sequences LANES consecutive byte reads from a base byte address. It packs the bytes into one vector word, little-endian by lane, and returns the word with a one-cycle done pulse. Arbitration between the two ports is round-robin. An error flag marks lanes that fall outside the image.

## Interface
- LANES, default 4: bytes (pixels) fetched and packed per request, LANES >= 1.
- IMG_BYTES, default 152100: number of valid image bytes. Addresses >= IMG_BYTES are out of bounds.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0, req1  in  1  request; held high with the address stable until the matching done is sampled.
- addr0, addr1  in  32  base byte address of the request.
- rom_addr  out  32  address to the image ROM.
- rom_rd  in  32  ROM read data, combinational from rom_addr; only bits [7:0] are used.
- data0, data1  out  8*LANES  packed result, lane i = data[8i+7:8i]; held until the next completion for that port.
- done0, done1  out  1  one-cycle pulse: the matching dataN is valid.
- err0, err1  out  1  valid with doneN; 1 if any lane address was out of bounds.
- busy  out  1  high while state is not IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - FETCH: idx counts 0..LANES-1.
  - DONE: one cycle, then back to IDLE.
- IDLE transitions:
  - Exactly one req high: grant that port.
  - Both high: grant the port not equal to last_owner.
  - Neither high: stay in IDLE.
- On grant, latch: base <= addrN, owner <= N, last_owner <= N, idx <= 0, lane error accumulator <= 0; go to FETCH.
- FETCH, each cycle:
  - rom_addr = base + idx. The add is 32-bit and wraps modulo 2^32.
  - At the edge, buf[idx] <= rom_rd[7:0], and err_acc |= (base+idx >= IMG_BYTES).
  - For an out-of-bounds lane, the byte is forced to 0 regardless of rom_rd.
  - At idx = LANES-1, go to DONE.
- On the edge leaving the last FETCH cycle:
  - data_owner <= {final byte, buf}.
  - err_owner <= final err_acc.
  - done_owner <= 1. This done is registered, so it is high exactly during the DONE cycle.
- rom_addr = 0 in IDLE and DONE.
- The non-owner's dataN and errN do not change.
- Arbitration happens only in IDLE. A request arriving during FETCH or DONE waits.
- If req drops mid-FETCH, the fetch still completes and done still pulses.
- Requester rule: deassert req at the edge where done is sampled. If req is still high in the following IDLE cycle, it is treated as a new request.
- Reset, asynchronous, may hit mid-operation:
  - state = IDLE, idx = 0, buf = 0.
  - rom_addr = 0, data0 = data1 = 0, done0 = done1 = 0, err0 = err1 = 0, busy = 0.
  - last_owner = 1, so port 0 wins the first contention.
  - The partial fetch is discarded and no done is issued for it.

## Timing
- The request is sampled high in IDLE at edge E0.
- FETCH occupies the LANES cycles after E0.
- done is high during cycle LANES+1 after E0.
- Request-to-done latency is LANES+1 cycles (5 for the default).
- Sustained throughput is one word per LANES+2 cycles (6), because each transaction passes through IDLE.
- rom_addr is registered-state driven and glitch-free per cycle; the ROM path is purely combinational within the FETCH cycle.
- done0 and done1 are never high in the same cycle.
- busy is 1 from the cycle after the grant edge through the DONE cycle inclusive.

## Test plan
- ROM model byte(a) = a[7:0] ^ 0x5A, a < 152100; otherwise 0.
- Reset then req0 with addr0 = 0x10 → data0 = 0x49484B4A, err0 = 0, done0 exactly 5 cycles after the grant edge, busy high for 5 cycles.
- req0 and req1 both asserted from reset, addr0 = 0, addr1 = 0x100 → port 0 done first (data0 = 0x59585B5A, the IMG_BYTES check passes), then port 1 (data1 = 0x59585B5A); 6 cycles between the two dones; a third contention grants port 0.
- addr1 = 152098 → lanes 0-1 = ROM bytes 0x??, lanes 2-3 = 0, so data1 = {8'h0, 8'h0, byte(152099), byte(152098)} = 0x00007978, err1 = 1.
- addr0 = 0xFFFFFFFE → lanes 2-3 wrap to addresses 0 and 1: data0 = 0x5B5A0000, err0 = 1.
- rst asserted during the 3rd FETCH cycle of a req0 → all outputs 0 immediately, no done0; after release, port 0 is granted first on contention.
- req1 dropped after 1 FETCH cycle → done1 still pulses with the full 4-byte word; a req0 arriving during FETCH is granted in the IDLE after DONE.
